// File: rtl/ex_stage_pkg.sv
// Shared widths, ID/EX field layout and divider state encoding for the MIPS execute stage.
package ex_stage_pkg;

    localparam int STALL_W      = 6;
    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;
    localparam int HILO_WD      = 65;

    localparam logic [5:0] FUNC_DIV  = 6'b011010;
    localparam logic [5:0] FUNC_DIVU = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    function automatic logic is_div_func(input logic [5:0] opcode, input logic [5:0] func);
        return (opcode == 6'd0) && ((func == FUNC_DIV) || (func == FUNC_DIVU));
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode/EX/MEM-facing buses of the execute stage, grouped for port connection.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
    logic [HILO_WD-1:0]      ex_hilo_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    stallreq_for_ex;

    modport master (
        input  id_to_ex_bus,
        output ex_to_mem_bus, ex_to_rf_bus, ex_hilo_bus,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output stallreq_for_ex
    );

    modport slave (
        output id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_rf_bus, ex_hilo_bus,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  stallreq_for_ex
    );

endinterface

// File: rtl/ex_stage_div_iter.sv
// 32-step radix-2 restoring divider for DIV/DIVU; operands are magnitudes, signs fixed on output.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic        ack,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    div_state_t  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] rq_q, rq_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] abs_a, abs_b;
    logic [32:0] trial;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rq_d    = rq_q;
        dvsr_d  = dvsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy    = 1'b0;
        done    = 1'b0;
        abs_a   = (signed_op && a[31]) ? -a : a;
        abs_b   = (signed_op && b[31]) ? -b : b;
        // Remainder (33 bits after the shift) against divisor; bit 32 set means borrow.
        trial   = rq_q[63:31] - {1'b0, dvsr_q};
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    busy    = 1'b1;
                    count_d = 5'd0;
                    if (b != 32'd0) begin
                        rq_d    = {32'd0, abs_a};
                        dvsr_d  = abs_b;
                        qneg_d  = signed_op & (a[31] ^ b[31]);
                        rneg_d  = signed_op & a[31];
                        state_d = DIV_RUN;
                    end else begin
                        rq_d    = {a, 32'hFFFF_FFFF};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_RUN: begin
                busy = 1'b1;
                if (trial[32]) rq_d = {rq_q[62:0], 1'b0};
                else           rq_d = {trial[31:0], rq_q[30:0], 1'b1};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                done = 1'b1;
                if (ack) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        q = qneg_q ? -rq_q[31:0]  : rq_q[31:0];
        r = rneg_q ? -rq_q[63:32] : rq_q[63:32];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            count_q <= 5'd0;
            rq_q    <= 64'd0;
            dvsr_q  <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rq_q    <= rq_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand select, 12-op ALU, data-SRAM request,
// iterative divider and the EX->MEM / bypass / HI-LO buses.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    ex_stage_if.master         bus
);

    id_to_ex_t   id_ex_q, id_ex_d;
    logic [31:0] imm_sext, imm_zext;
    logic [31:0] src1, src2, ex_result;
    logic [4:0]  sh;
    logic        slt_res, sltu_res;
    logic        div_busy, div_done;
    logic [31:0] div_q, div_r;
    logic        unused_ok;

    // Stopped here while MEM moves on: insert a bubble (all-zero is a NOP).
    always_comb begin
        id_ex_d = id_ex_q;
        if (stall[2] && !stall[3]) id_ex_d = '0;
        else if (!stall[2])        id_ex_d = id_to_ex_t'(bus.id_to_ex_bus);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) id_ex_q <= '0;
        else      id_ex_q <= id_ex_d;
    end

    always_comb begin
        imm_sext = {{16{id_ex_q.inst[15]}}, id_ex_q.inst[15:0]};
        imm_zext = {16'd0, id_ex_q.inst[15:0]};
        src1 = ({32{id_ex_q.sel_alu_src1[0]}} & id_ex_q.rdata1)
             | ({32{id_ex_q.sel_alu_src1[1]}} & id_ex_q.pc)
             | ({32{id_ex_q.sel_alu_src1[2]}} & {27'd0, id_ex_q.inst[10:6]});
        src2 = ({32{id_ex_q.sel_alu_src2[0]}} & id_ex_q.rdata2)
             | ({32{id_ex_q.sel_alu_src2[1]}} & imm_sext)
             | ({32{id_ex_q.sel_alu_src2[2]}} & 32'd8)
             | ({32{id_ex_q.sel_alu_src2[3]}} & imm_zext);
        sh       = src1[4:0];
        slt_res  = $signed(src1) < $signed(src2);
        sltu_res = src1 < src2;
        ex_result = ({32{id_ex_q.alu_op[11]}} & (src1 + src2))
                  | ({32{id_ex_q.alu_op[10]}} & (src1 - src2))
                  | ({32{id_ex_q.alu_op[9]}}  & {31'd0, slt_res})
                  | ({32{id_ex_q.alu_op[8]}}  & {31'd0, sltu_res})
                  | ({32{id_ex_q.alu_op[7]}}  & (src1 & src2))
                  | ({32{id_ex_q.alu_op[6]}}  & ~(src1 | src2))
                  | ({32{id_ex_q.alu_op[5]}}  & (src1 | src2))
                  | ({32{id_ex_q.alu_op[4]}}  & (src1 ^ src2))
                  | ({32{id_ex_q.alu_op[3]}}  & (src2 << sh))
                  | ({32{id_ex_q.alu_op[2]}}  & (src2 >> sh))
                  | ({32{id_ex_q.alu_op[1]}}  & 32'($signed(src2) >>> sh))
                  | ({32{id_ex_q.alu_op[0]}}  & {src2[15:0], 16'd0});
    end

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_func(id_ex_q.inst[31:26], id_ex_q.inst[5:0])),
        .signed_op (id_ex_q.inst[5:0] == FUNC_DIV),
        .ack       (!stall[2]),
        .a         (id_ex_q.rdata1),
        .b         (id_ex_q.rdata2),
        .busy      (div_busy),
        .done      (div_done),
        .q         (div_q),
        .r         (div_r)
    );

    assign bus.ex_to_mem_bus   = {id_ex_q.pc, id_ex_q.data_ram_en, id_ex_q.data_ram_wen,
                                  id_ex_q.sel_rf_res, id_ex_q.rf_we, id_ex_q.rf_waddr, ex_result};
    assign bus.ex_to_rf_bus    = {id_ex_q.rf_we, id_ex_q.rf_waddr, ex_result};
    assign bus.ex_hilo_bus     = div_done ? {1'b1, div_r, div_q} : '0;
    assign bus.data_sram_en    = id_ex_q.data_ram_en;
    assign bus.data_sram_wen   = id_ex_q.data_ram_wen;
    assign bus.data_sram_addr  = ex_result;
    assign bus.data_sram_wdata = id_ex_q.rdata2;
    assign bus.stallreq_for_ex = div_busy;

    assign unused_ok = ^{id_ex_q.inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against a behavioural ALU/divide model.
module tb_ex_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic [5:0] ext_stall;
    int         n_chk = 0;
    int         n_fail = 0;

    ex_stage_if ifc ();

    ex_stage u_dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // A stall controller freezes IF..EX while the divider asks for it.
    assign stall = ifc.stallreq_for_ex ? 6'b001111 : ext_stall;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic en,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic sr,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, sr, r1, r2};
    endfunction

    function automatic logic [31:0] model_alu(input logic [158:0] b);
        logic [31:0] pc, inst, r1, r2, x, y;
        logic [15:0] imm;
        pc = b[158:127]; inst = b[126:95]; r1 = b[63:32]; r2 = b[31:0];
        imm = inst[15:0];
        case (b[82:80])
            3'b001:  x = r1;
            3'b010:  x = pc;
            3'b100:  x = {27'd0, inst[10:6]};
            default: x = 32'd0;
        endcase
        case (b[79:76])
            4'b0001: y = r2;
            4'b0010: y = {{16{imm[15]}}, imm};
            4'b0100: y = 32'd8;
            4'b1000: y = {16'd0, imm};
            default: y = 32'd0;
        endcase
        case (b[94:83])
            12'h800: return x + y;
            12'h400: return x - y;
            12'h200: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            12'h100: return (x < y) ? 32'd1 : 32'd0;
            12'h080: return x & y;
            12'h040: return ~(x | y);
            12'h020: return x | y;
            12'h010: return x ^ y;
            12'h008: return y << x[4:0];
            12'h004: return y >> x[4:0];
            12'h002: return $signed(y) >>> x[4:0];
            12'h001: return {y[15:0], 16'd0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [158:0] b);
        ifc.id_to_ex_bus = b;
        @(negedge clk);
    endtask

    task automatic check_alu(input string tag, input logic [158:0] b);
        logic [31:0] res;
        res = model_alu(b);
        check({tag, "_mem_bus"}, ifc.ex_to_mem_bus, {b[158:127], b[75], b[74:71], b[64], b[70], b[69:65], res});
        check({tag, "_rf_bus"}, ifc.ex_to_rf_bus, {b[70], b[69:65], res});
        check({tag, "_sram_en"}, ifc.data_sram_en, b[75]);
        check({tag, "_sram_wen"}, ifc.data_sram_wen, b[74:71]);
        check({tag, "_sram_addr"}, ifc.data_sram_addr, res);
        check({tag, "_sram_wdata"}, ifc.data_sram_wdata, b[31:0]);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_cycles);
        int          cnt;
        logic [31:0] eq, er;
        int          sa, sb;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF; er = a;
        end else if (sgn) begin
            sa = a; sb = b;
            eq = sa / sb; er = sa % sb;
        end else begin
            eq = a / b; er = a % b;
        end
        ext_stall = 6'b000000;
        issue(mk(32'h0040_0100, {26'd0, sgn ? 6'b011010 : 6'b011011}, 12'd0, 3'd0, 4'd0,
                 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, a, b));
        cnt = 0;
        while (ifc.stallreq_for_ex && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, cnt, exp_cycles);
        check({tag, "_hilo"}, ifc.ex_hilo_bus, {1'b1, er, eq});
        ext_stall = 6'b001111;
        @(negedge clk);
        check({tag, "_hilo_held"}, ifc.ex_hilo_bus, {1'b1, er, eq});
        ext_stall = 6'b000000;
        issue('0);
        check({tag, "_hilo_cleared"}, ifc.ex_hilo_bus, 65'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [158:0] b;
        logic [31:0]  rnd, ra, rb;
        int           k, j1, j2;
        logic         sgn;

        rst = 1'b0;
        ext_stall = 6'b000000;
        ifc.id_to_ex_bus = mk(32'h1234_5678, 32'h2108_FFFF, 12'h800, 3'b001, 4'b0010,
                              1'b1, 4'hF, 1'b1, 5'd3, 1'b1, 32'd1, 32'd2);
        repeat (3) @(negedge clk);
        check("reset_mem_bus", ifc.ex_to_mem_bus, 76'd0);
        check("reset_rf_bus", ifc.ex_to_rf_bus, 38'd0);
        check("reset_hilo", ifc.ex_hilo_bus, 65'd0);
        check("reset_stallreq", ifc.stallreq_for_ex, 1'b0);
        check("reset_sram_en", ifc.data_sram_en, 1'b0);
        rst = 1'b1;

        // addiu $8, $x, -1 with rdata1 = 5
        b = mk(32'h0040_0000, 32'h2508_FFFF, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0,
               1'b1, 5'd8, 1'b0, 32'd5, 32'd0);
        issue(b);
        check("addiu_result", ifc.ex_to_mem_bus[31:0], 32'd4);
        check("addiu_waddr", ifc.ex_to_mem_bus[36:32], 5'd8);
        check("addiu_rf_bus", ifc.ex_to_rf_bus, {1'b1, 5'd8, 32'd4});

        // bubble: EX stopped, MEM running
        ext_stall = 6'b000110;
        @(negedge clk);
        ext_stall = 6'b000000;
        check("bubble_mem_bus", ifc.ex_to_mem_bus, 76'd0);
        check("bubble_rf_we", ifc.ex_to_rf_bus[37], 1'b0);
        check("bubble_sram_en", ifc.data_sram_en, 1'b0);

        issue(mk(32'h0040_0004, 32'h3C00_1234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0,
                 1'b1, 5'd9, 1'b0, 32'd0, 32'd0));
        check("lui_result", ifc.ex_to_rf_bus[31:0], 32'h1234_0000);
        issue(mk(32'h0040_0008, 32'h3400_000F, 12'h020, 3'b001, 4'b1000, 1'b0, 4'h0,
                 1'b1, 5'd10, 1'b0, 32'h0000_00F0, 32'd0));
        check("ori_result", ifc.ex_to_rf_bus[31:0], 32'h0000_00FF);

        // sw with base 0x1000, offset 8
        issue(mk(32'h0040_000C, 32'hAC00_0008, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF,
                 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF));
        check("sw_sram_en", ifc.data_sram_en, 1'b1);
        check("sw_sram_addr", ifc.data_sram_addr, 32'h0000_1008);
        check("sw_sram_wdata", ifc.data_sram_wdata, 32'hDEAD_BEEF);
        check("sw_sram_wen", ifc.data_sram_wen, 4'hF);

        // hold: both EX and MEM stopped keeps the register contents
        ext_stall = 6'b001111;
        ifc.id_to_ex_bus = '0;
        @(negedge clk);
        ext_stall = 6'b000000;
        check("hold_sram_addr", ifc.data_sram_addr, 32'h0000_1008);

        for (int i = 0; i < 60; i++) begin
            k   = $urandom_range(0, 11);
            j1  = $urandom_range(0, 3);
            j2  = $urandom_range(0, 4);
            rnd = $urandom();
            b = mk($urandom(), {6'h09, rnd[25:0]}, 12'h800 >> k,
                   (j1 == 3) ? 3'b000 : 3'(1 << j1), (j2 == 4) ? 4'b0000 : 4'(1 << j2),
                   1'($urandom()), 4'($urandom()), 1'($urandom()), 5'($urandom()),
                   1'($urandom()), $urandom(), $urandom());
            issue(b);
            check_alu($sformatf("alu%0d_op%0d", i, k), b);
        end
        check("alu_no_stallreq", ifc.stallreq_for_ex, 1'b0);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
        run_div("div_9_0", 1'b1, 32'd9, 32'd0, 1);
        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom());
            ra  = $urandom();
            rb  = $urandom() >> $urandom_range(0, 31);
            if (rb == 32'd0) rb = 32'd3;
            if (sgn && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd5;
            run_div($sformatf("rdiv%0d", i), sgn, ra, rb, 33);
        end

        // reset pulse while the divider is at RUN count 10
        issue(mk(32'h0040_0200, {26'd0, 6'b011010}, 12'd0, 3'd0, 4'd0, 1'b0, 4'h0,
                 1'b0, 5'd0, 1'b0, 32'd1000, 32'd3));
        repeat (11) @(negedge clk);
        check("midrst_busy_before", ifc.stallreq_for_ex, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midrst_stallreq", ifc.stallreq_for_ex, 1'b0);
        check("midrst_hilo", ifc.ex_hilo_bus, 65'd0);
        check("midrst_mem_bus", ifc.ex_to_mem_bus, 76'd0);
        ifc.id_to_ex_bus = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("postrst_stallreq", ifc.stallreq_for_ex, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Holds the ID/EX pipeline register, selects ALU operands, performs the 12 ALU ops, and issues data-SRAM requests for loads/stores.
- Runs a 32-iteration radix-2 divider for DIV/DIVU and raises a stall request while it is busy.
- Packs results onto the EX→MEM bus and a bypass bus back to decode.

Parameters:
- None. Widths come from `defines.vh`: StallBus=6, ID_TO_EX_WD=159, EX_TO_MEM_WD=76, EX_TO_RF_WD=38.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- stall  in  StallBus  pipeline stall vector; bit2 = this stage's input register, bit3 = MEM's input register
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}
- ex_to_mem_bus  out  76  {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
- ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}, bypass to decode
- ex_hilo_bus  out  65  {hilo_we, hi, lo}
- data_sram_en  out  1  data memory enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data
- stallreq_for_ex  out  1  divider busy

Behaviour:
- ID/EX register:
  - rst low → cleared.
  - Else if stall[2]=Stop and stall[3]=NoStop → load zero (bubble).
  - Else if stall[2]=NoStop → load id_to_ex_bus.
  - Otherwise hold.
  - An all-zero register is a NOP: no writes, no SRAM enable.
- Operand select, one-hot:
  - src1: [0] rdata1, [1] pc, [2] zero-extended inst[10:6].
  - src2: [0] rdata2, [1] sign-extended imm, [2] 32'd8, [3] zero-extended imm.
  - A zero select yields operand 0.
- ALU op order, MSB to LSB: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Arithmetic is 32-bit wrap with no overflow trap.
  - Shifts use src1[4:0] as the amount and src2 as the value.
  - lui = {src2[15:0], 16'b0}.
  - slt/sltu return 0 or 1.
  - Exactly one op bit set is expected; all zero → result 0.
- Memory interface (combinational, same cycle as EX):
  - data_sram_en = data_ram_en.
  - data_sram_wen = data_ram_wen.
  - data_sram_addr = ALU result (add).
  - data_sram_wdata = rdata2.
- Divider:
  - Triggers when inst[31:26]=0 and inst[5:0] is 011010 (DIV) or 011011 (DIVU).
  - FSM states: IDLE, RUN, DONE. State, count[4:0], 64-bit remainder/quotient register and sign flags are all async-cleared to IDLE/0.
  - IDLE with div present: stallreq=1. If divisor≠0, latch |rs| and |rt| (raw values for DIVU) → RUN, count=0. If divisor=0 → DONE with lo=FFFFFFFF, hi=rs.
  - RUN: one shift-subtract per cycle; stallreq=1; at count=31 → DONE.
  - DONE: stallreq=0; hilo_we=1 with final hi/lo.
    - DIV sign fix: quotient negated if the operand signs differ; remainder takes the dividend's sign.
    - Leave DONE → IDLE only when stall[2]=NoStop; otherwise stay in DONE and keep hilo_we=1 (idempotent).
  - Non-zero divide holds stallreq high for exactly 33 consecutive cycles; divide-by-zero holds it for 1 cycle.
- ex_hilo_bus is 0 whenever the FSM is not in DONE.
- Reset mid-division → IDLE immediately, stallreq=0, hilo_we=0.
- DIV/DIVU rf_we=0 comes from decode; no special casing in this stage.

Decomposition:
- `defines.vh` gains EX_TO_MEM_WD, EX_TO_RF_WD, and the DIV/DIVU func codes.
- Divider FSM is a sub-module `div_iter` with interface {clk, rst, start, signed_op, a, b, busy, done, q, r}.
- ALU stays inline.

Test Plan:
- addiu: rdata1=5, imm=FFFF, sel2[1], op_add, rf_we=1, waddr=8 → ex_to_mem result=4, waddr=8, ex_to_rf_bus mirrors it the same cycle.
- lui FFFF0 / ori: imm=1234 lui → 12340000; ori rdata1=0000_00F0, imm=000F → 000000FF.
- Bubble: stall=000110 with addiu in flight → next-cycle register all zero, data_sram_en=0, rf_we=0.
- DIVU 100/7 → stallreq high 33 cycles, then DONE hilo_we=1, lo=14, hi=2. DIV -7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV 9/0 → 1 stall cycle, lo=FFFFFFFF, hi=9. Reset pulse at RUN count=10 → stallreq=0 and registers cleared the same cycle.
- sw: rdata1=1000, offset=8, rdata2=DEADBEEF, wen=F → data_sram_en=1, addr=00001008, wdata=DEADBEEF, wen=F.
